// File: rtl/a23_cache_pkg.sv
// Shared types for the cache flush sequencer: FSM states, flush causes and
// the ranking used to pick a cause when several triggers coincide.
package a23_cache_pkg;

  localparam int WAYS_DEF  = 4;
  localparam int LINES_DEF = 256;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  typedef enum logic [1:0] {
    FLUSH_NONE    = 2'd0,
    FLUSH_CP15    = 2'd1,
    FLUSH_DISRUPT = 2'd2,
    FLUSH_SHRINK  = 2'd3
  } cause_t;

  // Higher rank wins: CP15 > area shrink > disruptive > none.
  function automatic logic [1:0] cause_rank(input cause_t c);
    case (c)
      FLUSH_CP15:    cause_rank = 2'd3;
      FLUSH_SHRINK:  cause_rank = 2'd2;
      FLUSH_DISRUPT: cause_rank = 2'd1;
      default:       cause_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/a23_cache_flush_seq_if.sv
// Invalidate command channel from the flush sequencer to the cache.
interface a23_cache_flush_seq_if #(
  parameter int WAY_W   = 2,
  parameter int INDEX_W = 8
);
  logic               inv_valid;
  logic               inv_ready;
  logic [WAY_W-1:0]   inv_way;
  logic [INDEX_W-1:0] inv_index;

  modport master (output inv_valid, inv_way, inv_index, input inv_ready);
  modport slave  (input inv_valid, inv_way, inv_index, output inv_ready);
endinterface

// File: rtl/a23_flush_walk_ctr.sv
// (way, index) walk counter: way is the fast digit, index the slow one.
module a23_flush_walk_ctr #(
  parameter int WAY_W   = 2,
  parameter int INDEX_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [WAY_W-1:0]   o_way,
  output logic [INDEX_W-1:0] o_index,
  output logic               o_last
);

  // Clear wins over advance; index steps when way wraps to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_way   <= '0;
      o_index <= '0;
    end else if (i_clr) begin
      o_way   <= '0;
      o_index <= '0;
    end else if (i_adv) begin
      o_way <= o_way + WAY_W'(1);
      if (&o_way) o_index <= o_index + INDEX_W'(1);
    end
  end

  assign o_last = (&o_way) & (&o_index);

endmodule

// File: rtl/a23_cache_flush_seq.sv
// Cache flush sequencer: collects flush triggers from CP15 and the fetch
// path, walks every way/index issuing invalidates, and stalls the core.
module a23_cache_flush_seq
  import a23_cache_pkg::*;
#(
  parameter int WAYS    = WAYS_DEF,
  parameter int LINES   = LINES_DEF,
  parameter int WAY_W   = $clog2(WAYS),
  parameter int INDEX_W = $clog2(LINES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fetch_stall,
  input  logic                   i_cache_flush,
  input  logic                   i_cache_enable,
  input  logic [31:0]            i_cacheable_area,
  input  logic                   i_disruptive_hit,
  a23_cache_flush_seq_if.master  inv,
  output logic                   o_flush_busy,
  output logic                   o_flush_done,
  output logic [1:0]             o_flush_cause
);

  state_t             state, state_nxt;
  logic [31:0]        prev_area;
  logic               pending;
  cause_t             pend_cause, cause_q;
  logic               trig_cp15, trig_shrink, trig_dis, any_trig;
  cause_t             trig_cause, merged_cause;
  logic               xfer, last, start_walk;
  logic [WAY_W-1:0]   ctr_way;
  logic [INDEX_W-1:0] ctr_index;

  // Cache enable does not gate flushing; kept on the port for visibility.
  logic unused_cache_enable;
  assign unused_cache_enable = i_cache_enable;

  // Trigger decode with cause priority, and merge against a pending cause.
  always_comb begin
    trig_cp15   = ~i_fetch_stall & i_cache_flush;
    trig_shrink = ~i_fetch_stall & (|(prev_area & ~i_cacheable_area));
    trig_dis    = ~i_fetch_stall & i_disruptive_hit;
    any_trig    = trig_cp15 | trig_shrink | trig_dis;
    if (trig_cp15)        trig_cause = FLUSH_CP15;
    else if (trig_shrink) trig_cause = FLUSH_SHRINK;
    else if (trig_dis)    trig_cause = FLUSH_DISRUPT;
    else                  trig_cause = FLUSH_NONE;
    merged_cause = (cause_rank(trig_cause) > cause_rank(pend_cause)) ? trig_cause : pend_cause;
  end

  assign xfer       = (state == WALK) & inv.inv_ready;
  assign start_walk = (state_nxt == WALK) & (state != WALK);

  a23_flush_walk_ctr #(.WAY_W(WAY_W), .INDEX_W(INDEX_W)) u_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (start_walk),
    .i_adv   (xfer),
    .o_way   (ctr_way),
    .o_index (ctr_index),
    .o_last  (last)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: a trigger seen during DONE restarts the walk directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_trig) state_nxt = WALK;
      WALK:    if (xfer && last) state_nxt = DONE;
      DONE:    state_nxt = (pending || any_trig) ? WALK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cause latch, pending re-run latch and previous area mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_area  <= '0;
      pending    <= 1'b0;
      pend_cause <= FLUSH_NONE;
      cause_q    <= FLUSH_NONE;
    end else begin
      if (!i_fetch_stall) prev_area <= i_cacheable_area;
      case (state)
        IDLE: if (any_trig) cause_q <= trig_cause;
        WALK: if (any_trig) begin
          pending    <= 1'b1;
          pend_cause <= merged_cause;
        end
        DONE: if (pending || any_trig) begin
          cause_q    <= merged_cause;
          pending    <= 1'b0;
          pend_cause <= FLUSH_NONE;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    inv.inv_valid = 1'b0;
    o_flush_busy  = 1'b0;
    o_flush_done  = 1'b0;
    if (state == WALK) inv.inv_valid = 1'b1;
    if (state != IDLE) o_flush_busy  = 1'b1;
    if (state == DONE) o_flush_done  = 1'b1;
  end

  assign inv.inv_way    = ctr_way;
  assign inv.inv_index  = ctr_index;
  assign o_flush_cause  = cause_q;

endmodule

// File: doc/a23_cache_flush_seq.md
Name: a23_cache_flush_seq

Overview:
Flush sequencer downstream of the CP15 coprocessor in the Amber 2 core. It consumes the coprocessor's flush strobe, cache enable and cacheable-area mask, plus a disruptive-region hit from the fetch path. It walks every way/index of the cache issuing invalidate commands over a valid/ready handshake. While a flush is in progress it holds the core stalled and reports completion and cause.

Parameters:
WAYS, 4, number of cache ways (power of 2)
LINES, 256, lines per way (power of 2)
WAY_W, 2, log2(WAYS)
INDEX_W, 8, log2(LINES)

Ports:
i_clk  in  1  core clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_fetch_stall  in  1  core-wide stall; triggers sampled only when low
i_cache_flush  in  1  single-cycle flush strobe from coprocessor (CP15 reg1 write)
i_cache_enable  in  1  cache on/off from coprocessor; informational only
i_cacheable_area  in  32  cacheable 2MB-region mask from coprocessor
i_disruptive_hit  in  1  fetch/data access hit a disruptive region this cycle
i_inv_ready  in  1  cache accepts invalidate command
o_inv_valid  out  1  invalidate command valid
o_inv_way  out  WAY_W  way to invalidate
o_inv_index  out  INDEX_W  line index to invalidate
o_flush_busy  out  1  sequencer active; core must stall
o_flush_done  out  1  one-cycle pulse when walk completes
o_flush_cause  out  2  cause of last/current flush: 0 none, 1 CP15, 2 disruptive, 3 area shrink

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_inv_valid=0, o_inv_way=0, o_inv_index=0, o_flush_busy=0, o_flush_done=0, o_flush_cause=0; pending=0; prev_area=0. A reset mid-walk abandons the walk; no done pulse.
- Trigger sources, sampled on rising edge only when i_fetch_stall=0:
  - CP15: i_cache_flush=1.
  - Disruptive: i_disruptive_hit=1.
  - Area shrink: (prev_area & ~i_cacheable_area) != 0.
- prev_area <= i_cacheable_area every edge with i_fetch_stall=0. Growth of the area never triggers.
- Cause priority when several triggers coincide: CP15 > area shrink > disruptive.
- States:
  - IDLE: on trigger -> WALK. Counters are cleared to 0 and cause is latched.
  - WALK: o_inv_valid=1. A command transfers when o_inv_valid & i_inv_ready. On transfer, way increments; when way wraps WAYS-1 -> 0, index increments. Transfer of (way=WAYS-1, index=LINES-1) -> DONE.
  - DONE: o_flush_done=1 for exactly one cycle. Next state is WALK (counters cleared, cause = pending cause, pending cleared) if pending=1, else IDLE.
- o_flush_busy=1 in WALK and DONE, registered from state. o_flush_cause holds its value in IDLE until the next trigger.
- While i_inv_ready=0, o_inv_valid/way/index are held stable; no counter advance.
- Trigger in WALK or DONE sets pending=1 and latches its cause (priority rule applies; a later trigger overwrites only with a higher-priority cause). Multiple triggers collapse into one re-run.
- A trigger in the same cycle DONE exits to IDLE is treated as pending, giving DONE -> WALK.
- Latency with i_inv_ready tied high: trigger sampled at edge N; first command visible in cycle N+1 (way 0, index 0); last transfer in cycle N+WAYS*LINES; o_flush_done in cycle N+WAYS*LINES+1; IDLE after that.
- Flush proceeds identically whether i_cache_enable is 0 or 1.
- No arithmetic beyond wrap-around counters. Way and index wrap to 0 modulo their widths.

Decomposition:
- Shared package a23_cache_pkg holds:
  - state enum {IDLE, WALK, DONE}
  - cause codes FLUSH_NONE/CP15/DISRUPT/SHRINK
  - defaults for WAYS/LINES
- One sub-module: a23_flush_walk_ctr, a (way,index) counter with clear, advance and terminal-count output.
- The FSM, trigger logic and pending latch stay in the top module.

Test Plan:
- Reset then i_cache_flush pulse at cycle 10, ready=1 -> valid cycles 11..1034, first (0,0), last (3,255); done pulse cycle 1035; busy=1 cycles 11..1035; cause=1.
- Ready toggling 1/0 every cycle during walk -> way/index never change while ready=0; exactly 1024 transfers in order; done after last transfer.
- i_cacheable_area 0x0000_0003 -> 0x0000_0001 -> flush with cause=3. Then 0x1 -> 0xF -> no flush.
- i_disruptive_hit at walk transfer #100, i_cache_flush at transfer #200 -> single re-run after done: DONE -> WALK directly, cause=1, total 2 done pulses.
- i_cache_flush and i_disruptive_hit together with i_fetch_stall=1 -> ignored, busy stays 0. The same inputs with stall=0 start a flush with cause=1.
- i_rst_n low at transfer #500 -> outputs zero immediately (async), no done pulse. A later flush starts at (0,0).
